mem_bist_ctrl: RTL and testbench

- Initiator-side built-in self-test engine for the single-port synchronous memory.
- Drives the memory's address, write-enable, read-enable and write-data port, and samples its read data one cycle after issuing a read.
- Runs a fixed three-phase march test: write P ascending; read P / write ~P ascending; read ~P descending.
- Reports pass/fail, the first failing address and data, and an error count. Sits between the test/config logic and the memory.

---
 rtl/mem_bist_pkg.sv | 33 +++
 rtl/mem_bist_if.sv | 14 +
 rtl/mem_bist_cmp.sv | 66 ++++++
 rtl/mem_bist_ctrl.sv | 139 +++++++++++++
 tb/tb_mem_bist_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bist_pkg.sv
// Shared state encodings and sizing helpers for the mem_bist march-test engine.
package mem_bist_pkg;

  localparam int unsigned StateWidth = 3;
  typedef logic [StateWidth-1:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StWrP   = 3'd1;
  localparam state_t StRw    = 3'd2;
  localparam state_t StRdN   = 3'd3;
  localparam state_t StDrain = 3'd4;
  localparam state_t StDone  = 3'd5;

  // err_cnt is ADDR_WIDTH + ErrCntExtraBits wide; wide enough for 2*D mismatches.
  localparam int unsigned ErrCntExtraBits = 2;

  function automatic int unsigned phase_len_wp(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned phase_len_rw(input int unsigned aw);
    return 32'd2 << aw;
  endfunction

  function automatic int unsigned phase_len_rn(input int unsigned aw);
    return 32'd1 << aw;
  endfunction

  function automatic int unsigned test_len(input int unsigned aw);
    return phase_len_wp(aw) + phase_len_rw(aw) + phase_len_rn(aw) + 32'd2;
  endfunction

endpackage

// File: rtl/mem_bist_if.sv
// Single-port synchronous memory port as seen by the BIST engine (master) and the memory (slave).
interface mem_bist_if #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output addr, output wr_en, output rd_en, output wr_data, input rd_data);
  modport slave  (input addr, input wr_en, input rd_en, input wr_data, output rd_data);
endinterface

// File: rtl/mem_bist_cmp.sv
// Read-compare pipeline: tracks each issued read for one cycle, detects mismatches,
// counts them (saturating) and captures the first failing address and data.
module mem_bist_cmp
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  clear,
  input  logic                                  issue,
  input  logic [ADDR_WIDTH-1:0]                 issue_addr,
  input  logic [DATA_WIDTH-1:0]                 issue_exp,
  input  logic [DATA_WIDTH-1:0]                 rd_data,
  output logic                                  mismatch,
  output logic                                  err_zero_next,
  output logic [ADDR_WIDTH+ErrCntExtraBits-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]                 fail_addr,
  output logic [DATA_WIDTH-1:0]                 fail_data
);

  localparam int unsigned CntWidth = ADDR_WIDTH + ErrCntExtraBits;

  logic                  valid_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] exp_q;
  logic [CntWidth-1:0]   err_cnt_q;
  logic [ADDR_WIDTH-1:0] fail_addr_q;
  logic [DATA_WIDTH-1:0] fail_data_q;

  assign mismatch      = valid_q && (rd_data != exp_q);
  assign err_zero_next = (err_cnt_q == '0) && !mismatch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q     <= 1'b0;
      addr_q      <= '0;
      exp_q       <= '0;
      err_cnt_q   <= '0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else begin
      valid_q <= issue;
      addr_q  <= issue_addr;
      exp_q   <= issue_exp;
      if (clear) begin
        err_cnt_q   <= '0;
        fail_addr_q <= '0;
        fail_data_q <= '0;
      end else if (mismatch) begin
        if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CntWidth'(1);
        // A zero count means this is the first mismatch of the test.
        if (err_cnt_q == '0) begin
          fail_addr_q <= addr_q;
          fail_data_q <= rd_data;
        end
      end
    end
  end

  assign err_cnt   = err_cnt_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-test BIST engine: write P up, read P / write ~P up, read ~P down.
// Define MEM_BIST_ABORT_EN to end the test on the first mismatch.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [DATA_WIDTH-1:0]                 pattern,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  pass,
  output logic [ADDR_WIDTH+ErrCntExtraBits-1:0] err_cnt,
  output logic [ADDR_WIDTH-1:0]                 fail_addr,
  output logic [DATA_WIDTH-1:0]                 fail_data,
  mem_bist_if.master                            mem
);

  localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  sub_q, sub_d;
  logic [DATA_WIDTH-1:0] pat_q, pat_d;
  logic                  pass_q, pass_d;
  logic                  accept, mismatch, err_zero_next;
  logic                  wr_op, rd_op, issue_ok;
  logic [DATA_WIDTH-1:0] rd_exp;

`ifdef MEM_BIST_ABORT_EN
  // Suppress the operation in the cycle the first mismatch is seen; DONE follows.
  assign issue_ok = !mismatch;
`else
  assign issue_ok = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sub_d   = sub_q;
    pat_d   = pat_q;
    accept  = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          state_d = StWrP;
          addr_d  = '0;
          sub_d   = 1'b0;
          pat_d   = pattern;
        end
      end
      StWrP: begin
        if (addr_q == AddrMax) begin
          state_d = StRw;
          addr_d  = '0;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
      StRw: begin
        sub_d = ~sub_q;
        if (sub_q) begin
          // Leaving RW at the top address, which is also where R_N starts.
          if (addr_q == AddrMax) state_d = StRdN;
          else                   addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      StRdN: begin
        if (addr_q == '0) state_d = StDrain;
        else              addr_d  = addr_q - ADDR_WIDTH'(1);
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef MEM_BIST_ABORT_EN
    if (mismatch) state_d = StDone;
`endif
    pass_d = pass_q;
    if (accept) pass_d = 1'b0;
    if ((state_d == StDone) && (state_q != StDone)) pass_d = err_zero_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      sub_q   <= 1'b0;
      pat_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sub_q   <= sub_d;
      pat_q   <= pat_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    wr_op  = (state_q == StWrP) || ((state_q == StRw) && sub_q);
    rd_op  = ((state_q == StRw) && !sub_q) || (state_q == StRdN);
    rd_exp = (state_q == StRdN) ? ~pat_q : pat_q;
  end

  assign mem.addr    = (wr_op || rd_op) ? addr_q : '0;
  assign mem.wr_en   = wr_op && issue_ok;
  assign mem.rd_en   = rd_op && issue_ok;
  assign mem.wr_data = (state_q == StWrP)            ? pat_q  :
                       ((state_q == StRw) && sub_q) ? ~pat_q : '0;

  assign busy = (state_q == StWrP) || (state_q == StRw) ||
                (state_q == StRdN) || (state_q == StDrain);
  assign done = (state_q == StDone);
  assign pass = pass_q;

  mem_bist_cmp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_cmp (
    .clk          (clk),
    .rst          (rst),
    .clear        (accept),
    .issue        (mem.rd_en),
    .issue_addr   (addr_q),
    .issue_exp    (rd_exp),
    .rd_data      (mem.rd_data),
    .mismatch     (mismatch),
    .err_zero_next(err_zero_next),
    .err_cnt      (err_cnt),
    .fail_addr    (fail_addr),
    .fail_data    (fail_data)
  );

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Scoreboard bench for mem_bist_ctrl: a march-test reference model queues expected memory
// operations and results; a monitor compares them against the DUT as they appear.
module tb_mem_bist_ctrl;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int D  = 1 << AW;
  localparam int CW = AW + 2;
  localparam int TestLen = 4 * D + 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] pattern = '0;
  logic          busy, done, pass;
  logic [CW-1:0] err_cnt;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;

  mem_bist_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

  mem_bist_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
    .fail_addr(fail_addr),
    .fail_data(fail_data),
    .mem      (mem_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model with one optional stuck-at bit.
  logic [DW-1:0] mem_arr [D];
  bit            fault_en = 0;
  logic [AW-1:0] fault_addr = '0;
  logic [DW-1:0] fault_mask = '0;
  bit            fault_val = 0;

  function automatic logic [DW-1:0] faulty(input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (fault_en && a == fault_addr) return fault_val ? (d | fault_mask) : (d & ~fault_mask);
    return d;
  endfunction

  always @(posedge clk) begin
    if (mem_if.wr_en) mem_arr[mem_if.addr] <= faulty(mem_if.addr, mem_if.wr_data);
    if (mem_if.rd_en) mem_if.rd_data <= mem_arr[mem_if.addr];
  end

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef struct packed {
    logic [31:0]   cyc;
    logic [CW-1:0] err_cnt;
    logic [AW-1:0] fail_addr;
    logic [DW-1:0] fail_data;
    logic          pass;
  } res_t;

  op_t  op_q[$];
  res_t res_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Reference: walk the march elements over an array, stop at first mismatch if aborting.
  task automatic expect_test(input logic [DW-1:0] p, input int c0);
    op_t           sched[$];
    op_t           o;
    logic [DW-1:0] m [D];
    int            errs = 0;
    int            stop = -1;
    logic [AW-1:0] fa = '0;
    logic [DW-1:0] fd = '0;
    res_t          r;
    for (int a = 0; a < D; a++) sched.push_back('{1'b1, AW'(a), p});
    for (int a = 0; a < D; a++) begin
      sched.push_back('{1'b0, AW'(a), p});
      sched.push_back('{1'b1, AW'(a), ~p});
    end
    for (int a = D - 1; a >= 0; a--) sched.push_back('{1'b0, AW'(a), ~p});
    foreach (sched[j]) begin
      if (stop < 0) begin
        o = sched[j];
        if (o.wr) begin
          m[o.addr] = faulty(o.addr, o.data);
          op_q.push_back(o);
        end else begin
          op_q.push_back('{1'b0, o.addr, {DW{1'b0}}});
          if (m[o.addr] != o.data) begin
            if (errs == 0) begin
              fa = o.addr;
              fd = m[o.addr];
            end
            errs++;
`ifdef MEM_BIST_ABORT_EN
            stop = j;
`endif
          end
        end
      end
    end
    r.cyc       = 32'(c0 + ((stop >= 0) ? stop + 3 : TestLen));
    r.err_cnt   = CW'((errs > (1 << CW) - 1) ? (1 << CW) - 1 : errs);
    r.fail_addr = fa;
    r.fail_data = fd;
    r.pass      = (errs == 0);
    res_q.push_back(r);
  endtask

  // Monitor: pops expectations whenever the DUT issues an operation or pulses done.
  initial forever begin
    op_t  e;
    res_t r;
    @(negedge clk);
    if (rst) begin
      if (mem_if.wr_en || mem_if.rd_en) begin
        if (op_q.size() == 0) begin
          check("unexpected_op", {30'b0, mem_if.wr_en, mem_if.rd_en}, 32'd0);
        end else begin
          e = op_q.pop_front();
          check("op_kind", {30'b0, mem_if.wr_en, mem_if.rd_en}, {30'b0, e.wr, !e.wr});
          check("op_addr", 32'(mem_if.addr), 32'(e.addr));
          if (e.wr) check("op_wdata", 32'(mem_if.wr_data), 32'(e.data));
        end
      end
      if (done) begin
        if (res_q.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          r = res_q.pop_front();
          check("done_cycle", 32'(cyc), r.cyc);
          check("busy_at_done", 32'(busy), 32'd0);
          check("err_cnt", 32'(err_cnt), 32'(r.err_cnt));
          check("fail_addr", 32'(fail_addr), 32'(r.fail_addr));
          check("fail_data", 32'(fail_data), 32'(r.fail_data));
          check("pass", 32'(pass), 32'(r.pass));
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    check({tag, "_fail_addr"}, 32'(fail_addr), 32'd0);
    check({tag, "_fail_data"}, 32'(fail_data), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_if.addr), 32'd0);
    check({tag, "_mem_en"}, {30'b0, mem_if.wr_en, mem_if.rd_en}, 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_if.wr_data), 32'd0);
  endtask

  task automatic set_fault(input bit en, input int a, input logic [DW-1:0] mask, input bit val);
    fault_en   = en;
    fault_addr = AW'(a);
    fault_mask = mask;
    fault_val  = val;
  endtask

  // Start one test; start stays high for 'hold' cycles; rst_at > 0 pulses reset in that cycle.
  task automatic run_test(input logic [DW-1:0] p, input int hold, input int rst_at);
    int c0;
    bit finished = 0;
    bit was_reset = 0;
    @(negedge clk);
    c0 = cyc;
    expect_test(p, c0);
    start   = 1'b1;
    pattern = p;
    for (int k = 1; k <= TestLen + 10 && !finished; k++) begin
      @(negedge clk);
      if (k == hold) begin
        start   = 1'b0;
        pattern = DW'($urandom);
      end
      if (k == 1) check("busy_after_start", 32'(busy), 32'd1);
      if (k == rst_at) begin
        #2 rst = 1'b0;
        #1 check_all_zero("async_rst");
        op_q.delete();
        res_q.delete();
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        finished  = 1;
        was_reset = 1;
      end else if (res_q.size() == 0) begin
        finished = 1;
      end
    end
    if (!finished) begin
      check("done_timeout", 32'(res_q.size()), 32'd0);
      res_q.delete();
    end
    repeat (2) @(negedge clk);
    if (!was_reset) check("ops_left", 32'(op_q.size()), 32'd0);
    op_q.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    run_test(8'hA5, 1, 0);
    set_fault(1, 2, 8'h01, 1);
    run_test(8'hA5, 1, 0);
    set_fault(1, 1, 8'h80, 0);
    run_test(8'hFF, 1, 0);
    set_fault(0, 0, 8'h00, 0);
    run_test(DW'($urandom), 10, 0);
    set_fault(1, 1, 8'h80, 0);
`ifdef MEM_BIST_ABORT_EN
    run_test(8'hFF, 1, 7);
`else
    run_test(8'hFF, 1, 10);
`endif
    set_fault(0, 0, 8'h00, 0);
    run_test(DW'($urandom), 1, 0);
    for (int i = 0; i < 6; i++) begin
      set_fault(bit'($urandom_range(0, 1)), int'($urandom_range(0, D - 1)),
                DW'(1 << $urandom_range(0, DW - 1)), bit'($urandom_range(0, 1)));
      run_test(DW'($urandom), int'($urandom_range(1, 6)), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
